// File: rtl/sdr_pkg.sv
// Shared definitions for the sample delay line: FSM / output-source encodings
// and the modular pointer subtraction used to locate the delayed sample.
package sdr_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } dl_state_t;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_RAM    = 2'd2
  } out_src_t;

  // (a - b) mod m for a < m and b <= m; avoids a divider and works for any m.
  function automatic int unsigned mod_sub(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned m);
    if (a >= b) return a - b;
    else        return a + m - b;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM with registered read; a read colliding with a write
// returns the old contents.
module delay_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 32,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable multi-channel delay line: delays a strobed sample
// stream by 0..MAX_DELAY accepted samples, re-priming on every delay change.
module var_delay_line
  import sdr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CH        = 2,
  parameter int MAX_DELAY = 64,
  parameter int FILL_MODE = 0,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       delay_sel,
  input  logic                in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [DW-1:0]       delay_cur,
  output logic                primed,
  output logic                clamp
);

  localparam int DataW = CH * WIDTH;
  localparam int PW    = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_DELAY - 1);

  logic [PW-1:0]    wr_ptr, rd_addr;
  logic [DW-1:0]    fill, fill_eff, d_eff;
  dl_state_t        state, state_eff;
  out_src_t         src;
  logic [DataW-1:0] byp_q, ram_q;
  logic             changed, take;

  // A delay change takes effect in the same cycle, so the incoming sample is
  // judged against the new delay with an emptied fill count.
  always_comb begin
    d_eff     = (delay_sel > MAX_D) ? MAX_D : delay_sel;
    changed   = (d_eff != delay_cur);
    fill_eff  = changed ? '0 : fill;
    state_eff = changed ? ST_FILL : state;
    take      = (state_eff == ST_RUN) || (fill_eff >= d_eff);
    rd_addr   = PW'(mod_sub(32'(wr_ptr), 32'(d_eff), 32'(MAX_DELAY)));
  end

  delay_ram #(
    .DEPTH (MAX_DELAY),
    .W     (DataW),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (in_valid),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      delay_cur <= '0;
      clamp     <= 1'b0;
      wr_ptr    <= '0;
      fill      <= '0;
      state     <= ST_FILL;
      src       <= SRC_ZERO;
      byp_q     <= '0;
    end else begin
      if (delay_sel > MAX_D) clamp <= 1'b1;
      delay_cur <= d_eff;
      if (in_valid) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        fill   <= (fill_eff == MAX_D) ? fill_eff : fill_eff + DW'(1);
        byp_q  <= in_data;
        if (take) begin
          state     <= ST_RUN;
          out_valid <= 1'b1;
          src       <= (d_eff == '0) ? SRC_BYPASS : SRC_RAM;
        end else begin
          state     <= ST_FILL;
          out_valid <= (FILL_MODE != 0);
          src       <= SRC_ZERO;
        end
      end else begin
        // Idle cycle: history and output word hold, only the strobe drops.
        out_valid <= 1'b0;
        fill      <= fill_eff;
        state     <= state_eff;
      end
    end
  end

  assign primed = (state == ST_RUN);

  always_comb begin
    out_data = '0;
    case (src)
      SRC_BYPASS: out_data = byp_q;
      SRC_RAM:    out_data = ram_q;
      default:    out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: three instances cover FILL_MODE 0/1 at
// MAX_DELAY=64 and a non-power-of-2 MAX_DELAY=5.
module tb_var_delay_line;

  localparam int WIDTH = 16;
  localparam int CH    = 2;
  localparam int DW_A  = 7;
  localparam int DW_C  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [CH*WIDTH-1:0] in_data;
  logic [DW_A-1:0]     delay_sel_a;
  logic [DW_C-1:0]     delay_sel_c;

  logic                ova, ovb, ovc;
  logic [CH*WIDTH-1:0] oda, odb, odc;
  logic [DW_A-1:0]     dca, dcb;
  logic [DW_C-1:0]     dcc;
  logic                pra, prb, prc;
  logic                cla, clb, clc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  var_delay_line #(.WIDTH(WIDTH), .CH(CH), .MAX_DELAY(64), .FILL_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .delay_sel(delay_sel_a), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ova), .out_data(oda), .delay_cur(dca),
    .primed(pra), .clamp(cla));

  var_delay_line #(.WIDTH(WIDTH), .CH(CH), .MAX_DELAY(64), .FILL_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .delay_sel(delay_sel_a), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ovb), .out_data(odb), .delay_cur(dcb),
    .primed(prb), .clamp(clb));

  var_delay_line #(.WIDTH(WIDTH), .CH(CH), .MAX_DELAY(5), .FILL_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .delay_sel(delay_sel_c), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ovc), .out_data(odc), .delay_cur(dcc),
    .primed(prc), .clamp(clc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample n: channel 0 = n, channel 1 = n with the top bit set.
  function automatic logic [31:0] pk(input int n);
    return {16'h8000 | 16'(n), 16'(n)};
  endfunction

  // Drive at a falling edge; on return the outputs reflect this strobe.
  task automatic step(input logic v, input int n);
    in_valid = v;
    in_data  = v ? pk(n) : '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    in_valid    = 1'b0;
    in_data     = '0;
    delay_sel_a = 7'd3;
    delay_sel_c = 3'd0;
    rst_n       = 1'b0;
    @(negedge clk);
    check("rst out_valid", 32'(ova), 0);
    check("rst out_data", oda, 0);
    check("rst delay_cur", 32'(dca), 0);
    check("rst primed", 32'(pra), 0);
    check("rst clamp", 32'(cla), 0);
    check("rst b out_valid", 32'(ovb), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Delay 3, continuous strobes: A waits 3 samples, B emits zeros meanwhile.
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, k);
      if (k <= 3) begin
        check("d3 a valid fill", 32'(ova), 0);
        check("d3 a primed fill", 32'(pra), 0);
        check("d3 b valid fill", 32'(ovb), 1);
        check("d3 b zero fill", odb, 0);
      end else begin
        check("d3 a valid", 32'(ova), 1);
        check("d3 a data", oda, pk(k - 3));
        check("d3 a primed", 32'(pra), 1);
        check("d3 b valid", 32'(ovb), 1);
        check("d3 b data", odb, pk(k - 3));
      end
    end
    check("d3 delay_cur", 32'(dca), 3);

    // Delay 0: bypass, valid from the first strobe.
    delay_sel_a = 7'd0;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 20 + k);
      check("d0 valid", 32'(ova), 1);
      check("d0 data", oda, pk(20 + k));
      check("d0 primed", 32'(pra), 1);
    end

    // Delay 2 with strobes on alternate cycles.
    delay_sel_a = 7'd2;
    do_reset();
    step(1'b1, 1); check("alt A valid", 32'(ova), 0);
    step(1'b0, 0); check("alt idle1", 32'(ova), 0);
    step(1'b1, 2); check("alt B valid", 32'(ova), 0);
    step(1'b0, 0); check("alt idle2", 32'(ova), 0);
    step(1'b1, 3); check("alt C valid", 32'(ova), 1); check("alt C data", oda, pk(1));
    step(1'b0, 0); check("alt idle3", 32'(ova), 0); check("alt hold", oda, pk(1));
    step(1'b1, 4); check("alt D valid", 32'(ova), 1); check("alt D data", oda, pk(2));
    step(1'b0, 0); check("alt idle4", 32'(ova), 0);

    // Delay 5 in RUN, then drop to 2 on a strobe.
    delay_sel_a = 7'd5;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, k);
      if (k >= 6) begin
        check("d5 valid", 32'(ova), 1);
        check("d5 data", oda, pk(k - 5));
      end
    end
    delay_sel_a = 7'd2;
    step(1'b1, 9);  check("chg s9 valid", 32'(ova), 0); check("chg s9 primed", 32'(pra), 0);
    check("chg delay_cur", 32'(dca), 2);
    step(1'b1, 10); check("chg s10 valid", 32'(ova), 0);
    step(1'b1, 11); check("chg s11 valid", 32'(ova), 1); check("chg s11 data", oda, pk(9));
    step(1'b1, 12); check("chg s12 data", oda, pk(10)); check("chg primed", 32'(pra), 1);

    // MAX_DELAY=5 instance: request 7 (largest 3-bit value above 5) -> clamp.
    do_reset();
    delay_sel_c = 3'd7;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, k);
      if (k <= 5) begin
        check("clamp fill valid", 32'(ovc), 0);
      end else begin
        check("clamp valid", 32'(ovc), 1);
        check("clamp data", odc, pk(k - 5));
      end
    end
    check("clamp delay_cur", 32'(dcc), 5);
    check("clamp flag", 32'(clc), 1);
    check("clamp primed", 32'(prc), 1);
    delay_sel_c = 3'd3;
    step(1'b1, 21);
    check("clamp sticky", 32'(clc), 1);
    check("clamp new delay", 32'(dcc), 3);
    check("clamp reprime", 32'(ovc), 0);
    step(1'b1, 22);
    // Asynchronous reset away from any rising edge.
    #2 rst_n = 1'b0;
    #1;
    check("async clamp", 32'(clc), 0);
    check("async primed", 32'(prc), 0);
    check("async out_valid", 32'(ovc), 0);
    check("async delay_cur", 32'(dcc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
